// File: rtl/rgb_channel_ctrl.sv
// rgb_channel_ctrl
//
// Shares one debounced rotary encoder and push button between the red,
// green and blue LED channels of the RGB mixer. Encoder detents step the
// brightness of the selected channel, a short press moves the selection
// R -> G -> B -> R, and a long press clears the selected channel. Every
// selection change briefly blanks the newly selected LED as feedback.
//
// Parameters:
//   width      bits per channel value (0 .. 2^width-1)
//   long_press consecutive high button samples that form a long press (>= 2)
//   blink      cycles the selection-feedback blank stays asserted (>= 1)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   step_up    one-cycle pulse, encoder moved one detent clockwise
//   step_down  one-cycle pulse, encoder moved one detent counter-clockwise
//   button     debounced push-button level, 1 = pressed
//   value_r    red brightness, registered
//   value_g    green brightness, registered
//   value_b    blue brightness, registered
//   sel        selected channel, 0 = R, 1 = G, 2 = B
//   blank      one-hot feedback, bit i forces LED i off at the top level

module rgb_channel_ctrl #(
  parameter int width      = 4,
  parameter int long_press = 8,
  parameter int blink      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_up,
  input  logic             step_down,
  input  logic             button,
  output logic [width-1:0] value_r,
  output logic [width-1:0] value_g,
  output logic [width-1:0] value_b,
  output logic [1:0]       sel,
  output logic [2:0]       blank
);

  localparam int press_w = $clog2(long_press) + 1;
  localparam int blink_w = $clog2(blink) + 1;

  localparam logic [width-1:0]   max_value  = '1;
  localparam logic [press_w-1:0] long_last  = press_w'(long_press - 1);
  localparam logic [blink_w-1:0] blink_load = blink_w'(blink);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } press_state_t;

  press_state_t       state;
  press_state_t       state_next;
  logic [press_w-1:0] press_cnt;
  logic [press_w-1:0] press_cnt_next;
  logic               short_fire;
  logic               long_fire;

  logic [blink_w-1:0] blink_cnt;
  logic [width-1:0]   sel_value;
  logic [width-1:0]   stepped_value;
  logic [1:0]         sel_next;

  // Press FSM state register and its press-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      press_cnt <= '0;
    end else begin
      state     <= state_next;
      press_cnt <= press_cnt_next;
    end
  end

  // Next-state logic. The counter holds the number of high samples seen so
  // far in this press; it stops at long_last when the press turns into a
  // hold, so it can never wrap.
  always_comb begin
    state_next     = state;
    press_cnt_next = press_cnt;
    case (state)
      IDLE: begin
        if (button) begin
          state_next     = PRESSED;
          press_cnt_next = press_w'(1);
        end
      end
      PRESSED: begin
        if (!button) begin
          state_next     = IDLE;
          press_cnt_next = '0;
        end else if (press_cnt == long_last) begin
          state_next = HELD;
        end else begin
          press_cnt_next = press_cnt + press_w'(1);
        end
      end
      HELD: begin
        if (!button) begin
          state_next     = IDLE;
          press_cnt_next = '0;
        end
      end
      default: begin
        state_next     = IDLE;
        press_cnt_next = '0;
      end
    endcase
  end

  // Press FSM outputs: a release before the long threshold is a short press,
  // reaching the threshold while still held fires the single long press.
  always_comb begin
    short_fire = (state == PRESSED) && !button;
    long_fire  = (state == PRESSED) && button && (press_cnt == long_last);
  end

  // New value for the selected channel. The clear takes priority over any
  // step landing on the same edge; both step pulses together cancel out.
  always_comb begin
    case (sel)
      2'd1:    sel_value = value_g;
      2'd2:    sel_value = value_b;
      default: sel_value = value_r;
    endcase

    stepped_value = sel_value;
    if (long_fire) begin
      stepped_value = '0;
    end else if (step_up && !step_down && (sel_value != max_value)) begin
      stepped_value = sel_value + width'(1);
    end else if (step_down && !step_up && (sel_value != '0)) begin
      stepped_value = sel_value - width'(1);
    end

    sel_next = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  end

  // Channel value registers. Only the channel named by the registered sel is
  // written, so a step on the release edge still lands on the old channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= '0;
      value_g <= '0;
      value_b <= '0;
    end else begin
      case (sel)
        2'd1:    value_g <= stepped_value;
        2'd2:    value_b <= stepped_value;
        default: value_r <= stepped_value;
      endcase
    end
  end

  // Selection and blink feedback. A selection change (re)loads the blink
  // counter and moves the blank bit; blank drops on the edge where the
  // counter runs out, giving exactly blink cycles of feedback.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= 2'd0;
      blink_cnt <= '0;
      blank     <= 3'b000;
    end else if (short_fire) begin
      sel       <= sel_next;
      blink_cnt <= blink_load;
      blank     <= 3'b001 << sel_next;
    end else if (blink_cnt != '0) begin
      blink_cnt <= blink_cnt - blink_w'(1);
      if (blink_cnt == blink_w'(1)) begin
        blank <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_rgb_channel_ctrl.sv
// tb_rgb_channel_ctrl
//
// Directed scenarios for reset, stepping, short/long presses, step/press
// interactions and mid-press reset, followed by a randomized run compared
// cycle by cycle against a behavioural model of the channel controller.

module tb_rgb_channel_ctrl;

  localparam int W     = 4;
  localparam int LP    = 8;
  localparam int BL    = 4;
  localparam int MAXV  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         step_up;
  logic         step_down;
  logic         button;
  logic [W-1:0] value_r;
  logic [W-1:0] value_g;
  logic [W-1:0] value_b;
  logic [1:0]   sel;
  logic [2:0]   blank;

  int checks = 0;
  int errors = 0;

  // Behavioural model: channel values, selection, length of the current run
  // of high button samples, and remaining blank cycles.
  int         m_val[3];
  int         m_sel;
  int         m_run;
  int         m_blink;
  logic [2:0] m_blank;

  rgb_channel_ctrl #(
    .width      (W),
    .long_press (LP),
    .blink      (BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step_up   (step_up),
    .step_down (step_down),
    .button    (button),
    .value_r   (value_r),
    .value_g   (value_g),
    .value_b   (value_b),
    .sel       (sel),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  // Model one rising edge from the inputs sampled at that edge.
  function automatic void model_edge(input logic up, input logic dn,
                                     input logic btn, input logic rst);
    bit short_press;
    int cur;
    short_press = 1'b0;
    if (rst) begin
      m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;
      m_sel = 0; m_run = 0; m_blink = 0; m_blank = 3'b000;
      return;
    end
    cur = m_sel;
    if (up && !dn && m_val[cur] < MAXV) m_val[cur] = m_val[cur] + 1;
    if (dn && !up && m_val[cur] > 0)    m_val[cur] = m_val[cur] - 1;
    if (btn) begin
      m_run = m_run + 1;
      if (m_run == LP) m_val[cur] = 0;
    end else begin
      if (m_run >= 1 && m_run < LP) short_press = 1'b1;
      m_run = 0;
    end
    if (short_press) begin
      m_sel   = (m_sel + 1) % 3;
      m_blink = BL;
      m_blank = 3'(1 << m_sel);
    end else if (m_blink > 0) begin
      m_blink = m_blink - 1;
      if (m_blink == 0) m_blank = 3'b000;
    end
  endfunction

  // Drive one cycle of inputs, let the edge happen, then sample #1 later.
  task automatic cycle(input logic up, input logic dn, input logic btn, input logic rst);
    step_up   = up;
    step_down = dn;
    button    = btn;
    reset     = rst;
    @(posedge clk);
    model_edge(up, dn, btn, rst);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++; if (value_r !== 4'd0) begin errors++; $display("[TB] FAIL reset_value_r got %0d expected 0", value_r); end
    checks++; if (value_g !== 4'd0) begin errors++; $display("[TB] FAIL reset_value_g got %0d expected 0", value_g); end
    checks++; if (value_b !== 4'd0) begin errors++; $display("[TB] FAIL reset_value_b got %0d expected 0", value_b); end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d expected 0", sel); end
    checks++; if (blank !== 3'b000) begin errors++; $display("[TB] FAIL reset_blank got %b expected 000", blank); end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_steps();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    checks++; if (value_r !== 4'd3) begin errors++; $display("[TB] FAIL step3_value_r got %0d expected 3", value_r); end
    checks++; if (value_g !== 4'd0 || value_b !== 4'd0) begin errors++; $display("[TB] FAIL step3_others got g=%0d b=%0d expected 0 0", value_g, value_b); end
    checks++; if (sel !== 2'd0 || blank !== 3'b000) begin errors++; $display("[TB] FAIL step3_sel_blank got sel=%0d blank=%b expected 0 000", sel, blank); end
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0);
    checks++; if (value_r !== 4'd15) begin errors++; $display("[TB] FAIL saturate_up got %0d expected 15", value_r); end
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
    checks++; if (value_r !== 4'd0) begin errors++; $display("[TB] FAIL saturate_down got %0d expected 0", value_r); end
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    checks++; if (value_r !== 4'd1) begin errors++; $display("[TB] FAIL both_steps got %0d expected 1", value_r); end
  endtask

  task automatic test_short_press();
    int on_cycles;
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL sel_before_release got %0d expected 0", sel); end
    cycle(0, 0, 0, 0);
    checks++; if (sel !== 2'd1) begin errors++; $display("[TB] FAIL sel_after_release got %0d expected 1", sel); end
    checks++; if (blank !== 3'b010) begin errors++; $display("[TB] FAIL blank_on_change got %b expected 010", blank); end
    on_cycles = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0);
      if (blank === 3'b010) on_cycles++;
    end
    checks++; if (on_cycles != BL) begin errors++; $display("[TB] FAIL blank_length got %0d expected %0d", on_cycles, BL); end
    checks++; if (blank !== 3'b000) begin errors++; $display("[TB] FAIL blank_cleared got %b expected 000", blank); end
    for (int p = 0; p < 2; p++) begin
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
    end
    checks++; if (sel !== 2'd0) begin errors++; $display("[TB] FAIL sel_wraps got %0d expected 0", sel); end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic test_long_press();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);
    checks++; if (sel !== 2'd1 || value_g !== 4'd9) begin errors++; $display("[TB] FAIL setup_g got sel=%0d g=%0d expected 1 9", sel, value_g); end
    for (int i = 0; i < LP - 1; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL hold7_short got sel=%0d expected 2", sel); end
    checks++; if (value_g !== 4'd9) begin errors++; $display("[TB] FAIL hold7_keeps_g got %0d expected 9", value_g); end
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < LP - 1; i++) cycle(0, 0, 1, 0);
    checks++; if (value_b !== 4'd9) begin errors++; $display("[TB] FAIL before_clear_b got %0d expected 9", value_b); end
    cycle(0, 0, 1, 0);
    checks++; if (value_b !== 4'd0) begin errors++; $display("[TB] FAIL long_clear_b got %0d expected 0", value_b); end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL held_release_sel got %0d expected 2", sel); end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic test_step_with_press();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    checks++; if (value_b !== 4'd1) begin errors++; $display("[TB] FAIL release_step_old_channel got %0d expected 1", value_b); end
    checks++; if (sel !== 2'd0 || value_r !== 4'd1) begin errors++; $display("[TB] FAIL release_step_sel got sel=%0d r=%0d expected 0 1", sel, value_r); end
    for (int i = 0; i < LP - 1; i++) cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    checks++; if (value_r !== 4'd0) begin errors++; $display("[TB] FAIL clear_beats_step got %0d expected 0", value_r); end
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    checks++; if ({value_r, value_g, value_b} !== 12'd0) begin errors++; $display("[TB] FAIL midpress_reset_values got %h expected 000", {value_r, value_g, value_b}); end
    checks++; if (sel !== 2'd0 || blank !== 3'b000) begin errors++; $display("[TB] FAIL midpress_reset_sel got sel=%0d blank=%b expected 0 000", sel, blank); end
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    checks++; if (value_r !== 4'd3) begin errors++; $display("[TB] FAIL fresh_press_no_early_clear got %0d expected 3", value_r); end
    cycle(0, 0, 1, 0);
    checks++; if (value_r !== 4'd0) begin errors++; $display("[TB] FAIL fresh_press_clear got %0d expected 0", value_r); end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    checks++; if (sel !== 2'd1 || blank !== 3'b010) begin errors++; $display("[TB] FAIL blink_setup got sel=%0d blank=%b expected 1 010", sel, blank); end
    cycle(0, 0, 0, 1);
    checks++; if (sel !== 2'd0 || blank !== 3'b000) begin errors++; $display("[TB] FAIL midblink_reset got sel=%0d blank=%b expected 0 000", sel, blank); end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic btn_level;
    int   run_left;
    logic up, dn, rst;
    btn_level = 1'b0;
    run_left  = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        btn_level = 1'($urandom_range(0, 1));
        run_left  = $urandom_range(1, 12);
      end
      run_left--;
      up  = ($urandom_range(0, 2) == 0);
      dn  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle(up, dn, btn_level, rst);
      checks++; if (value_r !== m_val[0][W-1:0]) begin errors++; $display("[TB] FAIL rand_value_r cycle %0d got %0d expected %0d", n, value_r, m_val[0]); end
      checks++; if (value_g !== m_val[1][W-1:0]) begin errors++; $display("[TB] FAIL rand_value_g cycle %0d got %0d expected %0d", n, value_g, m_val[1]); end
      checks++; if (value_b !== m_val[2][W-1:0]) begin errors++; $display("[TB] FAIL rand_value_b cycle %0d got %0d expected %0d", n, value_b, m_val[2]); end
      checks++; if (sel !== m_sel[1:0]) begin errors++; $display("[TB] FAIL rand_sel cycle %0d got %0d expected %0d", n, sel, m_sel); end
      checks++; if (blank !== m_blank) begin errors++; $display("[TB] FAIL rand_blank cycle %0d got %b expected %b", n, blank, m_blank); end
    end
  endtask

  initial begin
    step_up   = 1'b0;
    step_down = 1'b0;
    button    = 1'b0;
    reset     = 1'b1;
    m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;
    m_sel = 0; m_run = 0; m_blink = 0; m_blank = 3'b000;
    test_reset();
    test_steps();
    test_short_press();
    test_long_press();
    test_step_with_press();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_channel_ctrl.md
# rgb_channel_ctrl

Channel controller for the RGB mixer. It shares a single debounced rotary encoder and push button between the red, green and blue LED channels. It keeps three per-channel brightness values, steps the selected one on encoder detents, and changes the selection on a short press. A long press clears the selected channel. It sits between the encoder/debounce front end and the three per-channel PDM modulators.

## Interface
- `width`, default 4: bits per channel value; range 0 .. 2^width-1.
- `long_press`, default 8: consecutive sampled-high button cycles that make a long press; must be ≥ 2.
- `blink`, default 4: cycles the selection-feedback blank stays asserted after a selection change; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `step_up`  input  1  one-cycle pulse, encoder moved one detent clockwise.
- `step_down`  input  1  one-cycle pulse, encoder moved one detent counter-clockwise.
- `button`  input  1  debounced push-button level, 1 = pressed.
- `value_r`  output  width  red brightness, registered.
- `value_g`  output  width  green brightness, registered.
- `value_b`  output  width  blue brightness, registered.
- `sel`  output  2  selected channel: 0 = R, 1 = G, 2 = B. Value 3 is never produced.
- `blank`  output  3  one-hot selection feedback. Bit i high means the top level forces LED i off.

## Operation
- Reset (reset=1 sampled at a rising edge):
  - `value_r`, `value_g`, `value_b` = 0; `sel` = 0; `blank` = 3'b000.
  - Press FSM goes to IDLE; press counter and blink counter = 0.
- Encoder steps act on the channel named by the current registered `sel`:
  - `step_up` alone: value+1, saturating at 2^width-1.
  - `step_down` alone: value-1, saturating at 0.
  - Both high in the same cycle: no change.
  - Unselected channels never change on a step.
- Press FSM, states IDLE / PRESSED / HELD:
  - IDLE, button=1 → PRESSED, cnt=1. IDLE, button=0 → stay.
  - PRESSED, button=0 → IDLE and a short press fires: `sel` advances 0→1→2→0.
  - PRESSED, button=1, cnt==long_press-1 → HELD and a long press fires: the selected channel value becomes 0.
  - PRESSED, button=1, otherwise → cnt+1.
  - HELD, button=0 → IDLE, with no `sel` change. HELD, button=1 → stay; no further clears.
- Steps stay active in every FSM state.
- Clear versus step in the same cycle: the clear wins, and the value becomes 0.
- Blink feedback:
  - On every `sel` change the blink counter loads `blink`, and `blank` = one-hot of the new `sel`.
  - The counter decrements each cycle. `blank` returns to 0 when it reaches 0.
  - A new selection change during a blink reloads the counter and moves the blank bit to the new channel.
- Counter widths:
  - Press counter: clog2(long_press)+1 bits; it never wraps.
  - Blink counter: clog2(blink)+1 bits.

## Timing
- Step applied at edge N: the new value is visible after edge N, i.e. 1-cycle latency.
- Short press: `sel` updates at the edge that samples button=0 in PRESSED. A step sampled at that same edge applies to the old `sel`.
- Long press: the clear is visible after the edge that samples the long_press-th consecutive high.
- `blank` asserts at the same edge that `sel` changes and stays high for exactly `blink` cycles.
- A press held exactly long_press-1 cycles and then released is a short press.
- Reset mid-press or mid-blink: all state returns to its reset values at that edge. A button still held after reset has been released starts a fresh press, counted from IDLE.

## Test plan
Parameters for all scenarios: width=4, long_press=8, blink=4.
- Reset then 3 `step_up` pulses → `value_r`=3; `value_g`=`value_b`=0; `sel`=0; `blank`=0.
- 20 `step_up` pulses on R → `value_r` saturates at 15. Then 20 `step_down` pulses → 0, with no wrap. `step_up` and `step_down` high together → value unchanged.
- Button high 3 cycles then low → `sel`=1 after the release edge; `blank`=3'b010 for exactly 4 cycles. Three short presses → `sel` back to 0.
- On G with `value_g`=9, hold the button 7 cycles → short press, `sel`=2, `value_g`=9. Repeat on B with `value_b`=9 holding 8+ cycles → `value_b`=0 after the 8th high sample, `sel` unchanged on release.
- Step pulse on the same edge as a short-press release → the old channel increments, then `sel` advances. `step_up` on the long-press clear edge → value 0.
- Assert reset at press cycle 5 and during a blink → all outputs 0 next cycle. Button still high after reset → press counted anew from IDLE.
